// File: rtl/tlc_lamp_driver.sv
// Lamp, 7-segment and safety-monitor stage behind the traffic-light controller FSM.
// Registers the FSM codes, decodes lamps, counts seconds per state and latches faults.
module tlc_lamp_driver #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned REFRESH_CYCLES = 50000,
    parameter int unsigned BLINK_CYCLES   = 25000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] state,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    output logic [2:0] HwyLamp,
    output logic [2:0] FarmLamp,
    output logic [6:0] Seg,
    output logic [1:0] An,
    output logic       Fault,
    output logic [7:0] SecBcd
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;

    typedef enum logic {StNormal, StFault} mode_t;

    logic [2:0]    st1_q, st2_q;
    logic [1:0]    hwy1_q, farm1_q;
    mode_t         mode_q, mode_d;
    logic          trig;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d;
    logic [RW-1:0] ref_q, ref_d;
    logic          sel_q, sel_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          red_q, red_d;
    logic [2:0]    hwy_lamp_q, hwy_lamp_d, farm_lamp_q, farm_lamp_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    function automatic logic [2:0] lamp_decode(input logic [1:0] code);
        case (code)
            2'b11:   return 3'b001;
            2'b10:   return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        trig = (hwy1_q == 2'b01) || (farm1_q == 2'b01) ||
               ((hwy1_q != 2'b00) && (farm1_q != 2'b00));
        mode_d = mode_q;
        if (trig) mode_d = StFault;

        // Blink phase idles at "red on" so the first fault cycle shows red.
        blink_d = '0;
        red_d   = 1'b1;
        if (mode_q == StFault) begin
            blink_d = blink_q + BW'(1);
            red_d   = red_q;
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                red_d   = ~red_q;
            end
        end

        if (mode_d == StFault) begin
            hwy_lamp_d  = {red_d, 2'b00};
            farm_lamp_d = {red_d, 2'b00};
        end else begin
            hwy_lamp_d  = lamp_decode(hwy1_q);
            farm_lamp_d = lamp_decode(farm1_q);
        end

        presc_d = presc_q + PW'(1);
        ones_d  = ones_q;
        tens_d  = tens_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end
        if (st1_q != st2_q) begin
            presc_d = '0;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
        end

        ref_d = ref_q + RW'(1);
        sel_d = sel_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            sel_d = ~sel_q;
        end

        // Seg is built from next-state values so it always matches An and SecBcd.
        an_d  = sel_d ? 2'b01 : 2'b10;
        seg_d = (mode_d == StFault) ? SEG_DASH : glyph(sel_d ? tens_d : ones_d);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st1_q       <= 3'b000;
            st2_q       <= 3'b000;
            hwy1_q      <= 2'b00;
            farm1_q     <= 2'b00;
            mode_q      <= StNormal;
            presc_q     <= '0;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            ref_q       <= '0;
            sel_q       <= 1'b0;
            blink_q     <= '0;
            red_q       <= 1'b1;
            hwy_lamp_q  <= 3'b100;
            farm_lamp_q <= 3'b100;
            seg_q       <= 7'b1000000;
            an_q        <= 2'b10;
        end else begin
            st1_q       <= state;
            st2_q       <= st1_q;
            hwy1_q      <= highwaySignal;
            farm1_q     <= farmSignal;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            ref_q       <= ref_d;
            sel_q       <= sel_d;
            blink_q     <= blink_d;
            red_q       <= red_d;
            hwy_lamp_q  <= hwy_lamp_d;
            farm_lamp_q <= farm_lamp_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign HwyLamp  = hwy_lamp_q;
    assign FarmLamp = farm_lamp_q;
    assign Seg      = seg_q;
    assign An       = an_q;
    assign Fault    = (mode_q == StFault);
    assign SecBcd   = {tens_q, ones_q};

endmodule

// File: tb/tb_tlc_lamp_driver.sv
// Scoreboard bench for tlc_lamp_driver: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_tlc_lamp_driver;

    localparam int SIG_HWY  = 0;
    localparam int SIG_FARM = 1;
    localparam int SIG_SEG  = 2;
    localparam int SIG_AN   = 3;
    localparam int SIG_FLT  = 4;
    localparam int SIG_SEC  = 5;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [2:0] state = 3'b000;
    logic [1:0] highwaySignal = 2'b00;
    logic [1:0] farmSignal = 2'b00;
    logic [2:0] HwyLamp, FarmLamp;
    logic [6:0] Seg;
    logic [1:0] An;
    logic       Fault;
    logic [7:0] SecBcd;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   failures = 0;

    tlc_lamp_driver #(
        .CLK_HZ        (10),
        .REFRESH_CYCLES(4),
        .BLINK_CYCLES  (3)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .state        (state),
        .highwaySignal(highwaySignal),
        .farmSignal   (farmSignal),
        .HwyLamp      (HwyLamp),
        .FarmLamp     (FarmLamp),
        .Seg          (Seg),
        .An           (An),
        .Fault        (Fault),
        .SecBcd       (SecBcd)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [7:0] get_sig(input int s);
        case (s)
            SIG_HWY:  return {5'b0, HwyLamp};
            SIG_FARM: return {5'b0, FarmLamp};
            SIG_SEG:  return {1'b0, Seg};
            SIG_AN:   return {6'b0, An};
            SIG_FLT:  return {7'b0, Fault};
            default:  return SecBcd;
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic expect_reset(input int c);
        expect_at(c, SIG_HWY, 8'b100, "rst_hwy");
        expect_at(c, SIG_FARM, 8'b100, "rst_farm");
        expect_at(c, SIG_SEG, 8'b1000000, "rst_seg");
        expect_at(c, SIG_AN, 8'b10, "rst_an");
        expect_at(c, SIG_FLT, 8'd0, "rst_fault");
        expect_at(c, SIG_SEC, 8'h00, "rst_sec");
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Monitor: compare every queued expectation due on this cycle.
    always @(negedge Clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [7:0] act;
                act = get_sig(sb[i].sig);
                tests++;
                if (act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s @cyc %0d: got %b, want %b", sb[i].name, cyc, act,
                             sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                tests++;
                failures++;
                $display("FAIL %s: check for cyc %0d never sampled", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        // Scenario 1: reset
        tick(2);
        expect_reset(2);

        // Scenario 2: normal operation; state-change clear lands on edge 4
        Rst = 1'b0;
        state = 3'b001;
        highwaySignal = 2'b11;
        farmSignal = 2'b00;
        expect_at(3, SIG_HWY, 8'b100, "lat_hwy_old");
        expect_at(4, SIG_HWY, 8'b001, "hwy_green");
        expect_at(4, SIG_FARM, 8'b100, "farm_red");
        expect_at(4, SIG_SEC, 8'h00, "sec_clear");
        expect_at(13, SIG_SEC, 8'h00, "sec_pre1");
        expect_at(14, SIG_SEC, 8'h01, "sec_1");
        expect_at(23, SIG_SEC, 8'h01, "sec_pre2");
        expect_at(24, SIG_SEC, 8'h02, "sec_2");
        expect_at(129, SIG_SEC, 8'h12, "sec_12");
        expect_at(131, SIG_SEC, 8'h12, "sec_before_clr");

        // Scenario 3: state change clears, then saturates at 99 (clear on edge 132)
        tick(128);
        state = 3'b010;
        highwaySignal = 2'b10;
        expect_at(132, SIG_SEC, 8'h00, "sec_clr2");
        expect_at(132, SIG_HWY, 8'b010, "hwy_yellow");
        expect_at(132, SIG_FARM, 8'b100, "farm_red2");
        expect_at(1121, SIG_SEC, 8'h98, "sec_98");
        expect_at(1122, SIG_SEC, 8'h99, "sec_99");
        expect_at(1232, SIG_SEC, 8'h99, "sec_sat");

        // Scenario 4: display mux at 37 (clear on edge 1242, refresh phase from reset release)
        tick(1110);
        state = 3'b011;
        for (int c = 1612; c <= 1619; c++) begin
            int sel;
            sel = ((c - 2) / 4) % 2;
            expect_at(c, SIG_AN, (sel != 0) ? 8'b01 : 8'b10, "mux_an");
            expect_at(c, SIG_SEG, (sel != 0) ? 8'b0110000 : 8'b1111000, "mux_seg");
        end
        expect_at(1612, SIG_SEC, 8'h37, "sec_37");
        expect_at(1621, SIG_SEC, 8'h37, "sec_37_end");
        expect_at(1622, SIG_SEC, 8'h38, "sec_38");

        // Scenario 5: one-cycle illegal farm code
        tick(390);
        farmSignal = 2'b01;
        expect_at(1631, SIG_FLT, 8'd0, "fault_lat");
        expect_at(1632, SIG_FLT, 8'd1, "fault_set");
        expect_at(1632, SIG_SEG, 8'b0111111, "seg_dash");
        expect_at(1640, SIG_SEG, 8'b0111111, "seg_dash2");
        for (int c = 1632; c <= 1643; c++) begin
            logic [7:0] lamp;
            lamp = ((((c - 1632) / 3) % 2) != 0) ? 8'b000 : 8'b100;
            expect_at(c, SIG_HWY, lamp, "blink_hwy");
            expect_at(c, SIG_FARM, lamp, "blink_farm");
        end
        expect_at(1640, SIG_SEC, 8'h39, "sec_in_fault");
        expect_at(1660, SIG_FLT, 8'd1, "fault_sticky");
        tick(1);
        farmSignal = 2'b00;
        tick(39);

        // Reset from fault returns to scenario-1 values
        Rst = 1'b1;
        state = 3'b000;
        highwaySignal = 2'b00;
        expect_reset(1671);
        expect_reset(1672);
        tick(2);

        // Scenario 6: conflict
        Rst = 1'b0;
        highwaySignal = 2'b11;
        farmSignal = 2'b10;
        expect_at(1673, SIG_FLT, 8'd0, "conf_lat");
        expect_at(1674, SIG_FLT, 8'd1, "conf_fault");
        expect_at(1674, SIG_HWY, 8'b100, "conf_hwy");
        expect_at(1674, SIG_FARM, 8'b100, "conf_farm");
        tick(8);
        Rst = 1'b1;
        for (int c = 1681; c <= 1685; c++) expect_at(c, SIG_FLT, 8'd0, "rst_conf");
        expect_at(1681, SIG_HWY, 8'b100, "rst_conf_hwy");
        tick(2);
        Rst = 1'b0;
        highwaySignal = 2'b00;
        farmSignal = 2'b00;
        tick(8);
        Rst = 1'b1;
        highwaySignal = 2'b11;
        farmSignal = 2'b11;
        for (int c = 1691; c <= 1695; c++) expect_at(c, SIG_FLT, 8'd0, "rst_simul");
        tick(2);
        Rst = 1'b0;
        highwaySignal = 2'b00;
        farmSignal = 2'b00;
        tick(10);
        #10;

        tests++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
